// File: rtl/cache_fill_controller_pkg.sv
// Shared types and constants for the cache miss fill controller.
// Block geometry defaults and the FSM state encoding live here.
package cache_fill_controller_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_fill_controller_if.sv
// Bundle of cache miss, main-memory and fill-write signals around the controller.
// master: caches and main memory; slave: the fill controller.
interface cache_fill_controller_if
  import cache_fill_controller_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic                  i_miss;
  logic [ADDR_W-1:0]     i_miss_addr;
  logic                  d_miss;
  logic [ADDR_W-1:0]     d_miss_addr;
  logic                  mem_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_data_valid;
  logic [ADDR_W-1:0]     mem_data;
  logic [ADDR_W-1:0]     fill_data;
  logic [WORD_IDX_W-1:0] fill_word;
  logic                  i_data_we;
  logic                  d_data_we;
  logic                  i_tag_we;
  logic                  d_tag_we;
  logic                  i_fill_done;
  logic                  d_fill_done;
  logic                  busy;

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_data, fill_word, i_data_we, d_data_we,
           i_tag_we, d_tag_we, i_fill_done, d_fill_done, busy
  );

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_data, fill_word, i_data_we, d_data_we,
           i_tag_we, d_tag_we, i_fill_done, d_fill_done, busy
  );

endinterface

// File: rtl/fill_word_counter.sv
// Word counter with synchronous clear and count enable; clear wins over enable.
module fill_word_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cache_fill_controller.sv
// Services one held I- or D-cache miss at a time: issues the block's word reads,
// streams returned words into the selected cache, then writes the tag and signals done.
module cache_fill_controller
  import cache_fill_controller_pkg::fill_state_t,
         cache_fill_controller_pkg::IDLE,
         cache_fill_controller_pkg::FILL,
         cache_fill_controller_pkg::DONE,
         cache_fill_controller_pkg::BLOCK_MASK;
#(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = cache_fill_controller_pkg::WORDS_PER_BLOCK,
  parameter int OFFSET_BITS     = cache_fill_controller_pkg::OFFSET_BITS
) (
  input logic                     clk,
  input logic                     rst,
  cache_fill_controller_if.slave  bus
);

  localparam int ISSUE_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int RECV_W  = $clog2(WORDS_PER_BLOCK);
  localparam logic [ISSUE_W-1:0] ISSUE_END = ISSUE_W'(WORDS_PER_BLOCK);
  localparam logic [RECV_W-1:0]  LAST_RECV = RECV_W'(WORDS_PER_BLOCK - 1);
  // Package mask is the default; the parameterised shift covers wider offsets.
  localparam logic [ADDR_W-1:0]  ADDR_MASK =
      ADDR_W'(BLOCK_MASK) & ({ADDR_W{1'b1}} << OFFSET_BITS);

  fill_state_t        state_reg, state_next;
  logic               sel_d_reg, sel_d_next;
  logic [ADDR_W-1:0]  base_reg, base_next;

  logic [ISSUE_W-1:0] issue_cnt;
  logic [RECV_W-1:0]  recv_cnt;
  logic               cnt_clr;
  logic               issue_en;
  logic               recv_fire;
  logic               last_word;

  logic [1:0]         data_we;
  logic [1:0]         tag_we;
  logic [1:0]         fill_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_d_reg <= 1'b0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sel_d_reg <= sel_d_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_d_next = sel_d_reg;
    base_next  = base_reg;
    case (state_reg)
      IDLE: begin
        // D-cache wins a tie; a losing I miss stays held and is taken later.
        if (bus.d_miss) begin
          sel_d_next = 1'b1;
          base_next  = bus.d_miss_addr & ADDR_MASK;
          state_next = FILL;
        end else if (bus.i_miss) begin
          sel_d_next = 1'b0;
          base_next  = bus.i_miss_addr & ADDR_MASK;
          state_next = FILL;
        end
      end
      FILL: begin
        if (recv_fire && last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Both counters restart in every IDLE cycle, so a fill always begins from zero.
  assign cnt_clr   = (state_reg == IDLE);
  assign issue_en  = (state_reg == FILL) && (issue_cnt < ISSUE_END);
  assign recv_fire = (state_reg == FILL) && bus.mem_data_valid;
  assign last_word = (recv_cnt == LAST_RECV);

  fill_word_counter #(
    .WIDTH (ISSUE_W)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (issue_en),
    .count (issue_cnt)
  );

  fill_word_counter #(
    .WIDTH (RECV_W)
  ) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (recv_fire),
    .count (recv_cnt)
  );

  // Words are 16 bits, so consecutive word addresses step by two bytes.
  assign bus.mem_en    = issue_en;
  assign bus.mem_addr  = issue_en ? (base_reg + (ADDR_W'(issue_cnt) << 1)) : '0;
  assign bus.fill_data = recv_fire ? bus.mem_data : '0;
  assign bus.fill_word = recv_fire ? recv_cnt : '0;
  assign bus.busy      = (state_reg != IDLE);

  // Index 0 is the I-cache, index 1 the D-cache.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cache
    logic is_sel;
    assign is_sel        = (sel_d_reg == 1'(gi));
    assign data_we[gi]   = recv_fire & is_sel;
    assign tag_we[gi]    = recv_fire & last_word & is_sel;
    assign fill_done[gi] = (state_reg == DONE) & is_sel;
  end

  assign bus.i_data_we   = data_we[0];
  assign bus.d_data_we   = data_we[1];
  assign bus.i_tag_we    = tag_we[0];
  assign bus.d_tag_we    = tag_we[1];
  assign bus.i_fill_done = fill_done[0];
  assign bus.d_fill_done = fill_done[1];

endmodule

// File: tb/tb_cache_fill_controller.sv
// Self-checking bench: a 4-cycle memory model feeds the controller and every
// observed issue/write/tag/done event is compared with a per-fill event schedule.
module tb_cache_fill_controller;

  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0]  kind;   // 0 issue, 1 data write, 2 tag write, 3 fill done
    logic        d;
    logic [2:0]  word;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   exp_busy = 0;
  logic tog = 1'b0;
  logic [15:0] salt;
  ev_t  ev_q[$];
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_fill_controller_if bus ();

  cache_fill_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ salt;
  endfunction

  function automatic ev_t mk(input logic [1:0] kind, input int c, input logic d,
                             input logic [2:0] w, input logic [15:0] data);
    ev_t e;
    e.cyc  = 16'(c);
    e.kind = kind;
    e.d    = d;
    e.word = w;
    e.data = data;
    return e;
  endfunction

  function automatic logic [42:0] out_vec();
    return {bus.mem_en, bus.mem_addr, bus.fill_data, bus.fill_word,
            bus.i_data_we, bus.d_data_we, bus.i_tag_we, bus.d_tag_we,
            bus.i_fill_done, bus.d_fill_done, bus.busy};
  endfunction

  // Reference schedule of one fill whose miss is first seen in IDLE at cycle t0.
  task automatic model_fill(input int t0, input logic d, input logic [15:0] miss_addr);
    logic [15:0] base;
    base = miss_addr - (miss_addr % 16'd16);
    for (int c = t0 + 1; c <= t0 + 13; c++) begin
      if (c - t0 - 1 < 8)
        exp_q.push_back(mk(2'd0, c, 1'b0, 3'd0, base + 16'(2 * (c - t0 - 1))));
      if (c - t0 >= 5 && c - t0 <= 12)
        exp_q.push_back(mk(2'd1, c, d, 3'(c - t0 - 5), mem_fn(base + 16'(2 * (c - t0 - 5)))));
      if (c == t0 + 12) exp_q.push_back(mk(2'd2, c, d, 3'd0, 16'd0));
      if (c == t0 + 13) exp_q.push_back(mk(2'd3, c, d, 3'd0, 16'd0));
    end
    exp_busy += 13;
  endtask

  // Main memory: a read issued in cycle c returns its word in cycle c+4.
  initial begin
    logic [3:0]  pv;
    logic [15:0] pa [4];
    logic        out_v;
    logic [15:0] out_a;
    pv = '0;
    for (int k = 0; k < 4; k++) pa[k] = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk); #1;
      out_v = pv[3];
      out_a = pa[3];
      for (int k = 3; k > 0; k--) begin
        pv[k] = pv[k-1];
        pa[k] = pa[k-1];
      end
      pv[0] = bus.mem_en;
      pa[0] = bus.mem_addr;
      bus.mem_data_valid = out_v | tog;
      bus.mem_data = out_v ? mem_fn(out_a) : 16'($urandom);
    end
  end

  // Event monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1)      ev_q.push_back(mk(2'd0, cyc, 1'b0, 3'd0, bus.mem_addr));
      if (bus.i_data_we === 1'b1)   ev_q.push_back(mk(2'd1, cyc, 1'b0, bus.fill_word, bus.fill_data));
      if (bus.d_data_we === 1'b1)   ev_q.push_back(mk(2'd1, cyc, 1'b1, bus.fill_word, bus.fill_data));
      if (bus.i_tag_we === 1'b1)    ev_q.push_back(mk(2'd2, cyc, 1'b0, 3'd0, 16'd0));
      if (bus.d_tag_we === 1'b1)    ev_q.push_back(mk(2'd2, cyc, 1'b1, 3'd0, 16'd0));
      if (bus.i_fill_done === 1'b1) ev_q.push_back(mk(2'd3, cyc, 1'b0, 3'd0, 16'd0));
      if (bus.d_fill_done === 1'b1) ev_q.push_back(mk(2'd3, cyc, 1'b1, 3'd0, 16'd0));
      if (bus.busy === 1'b1)        busy_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ev_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    exp_busy = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      tog = ~tog;
      @(negedge clk);
      checks++;
      if (out_vec() !== 43'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h want 0", k, out_vec());
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      tog = ~tog;
      @(negedge clk);
      checks++;
      if (out_vec() !== 43'd0) begin
        errors++;
        $display("FAIL idle_valid_ignored cycle %0d got %h want 0", k, out_vec());
      end
      @(posedge clk); #1;
    end
    tog = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_events got %0d want 0", ev_q.size());
    end
    $display("reset: idle with toggling valid, events %0d", ev_q.size());
  endtask

  task automatic test_single_fill(input string name, input logic d, input logic [15:0] a);
    int  t0;
    bit  seen;
    @(posedge clk); #1;
    clear_logs();
    t0 = cyc;
    if (d) begin bus.d_miss = 1'b1; bus.d_miss_addr = a; end
    else   begin bus.i_miss = 1'b1; bus.i_miss_addr = a; end
    model_fill(t0, d, a);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if ((d ? bus.d_fill_done : bus.i_fill_done) === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout got no done want done", name); end
    @(posedge clk); #1;
    bus.i_miss = 1'b0;
    bus.d_miss = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_event_count got %0d want %0d", name, ev_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < ev_q.size(); k++) begin
      checks++;
      if (ev_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s_event%0d got %h want %h", name, k, ev_q[k], exp_q[k]);
      end
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_cnt, exp_busy);
    end
    $display("%s: %s miss %h, events %0d", name, d ? "D" : "I", a, ev_q.size());
  endtask

  task automatic test_i_fill();
    for (int r = 0; r < 3; r++)
      test_single_fill("i_fill", 1'b0, (r == 0) ? 16'h1236 : 16'($urandom));
  endtask

  task automatic test_boundary();
    test_single_fill("boundary", 1'b1, 16'hFFFE);
    test_single_fill("boundary", 1'b0, 16'hFFF0 | 16'($urandom_range(0, 15)));
  endtask

  task automatic test_back_to_back();
    int t0;
    bit seen;
    logic [15:0] ia, da;
    for (int r = 0; r < 2; r++) begin
      ia = (r == 0) ? 16'h0040 : 16'($urandom);
      da = (r == 0) ? 16'h8008 : 16'($urandom);
      @(posedge clk); #1;
      clear_logs();
      t0 = cyc;
      bus.i_miss = 1'b1; bus.i_miss_addr = ia;
      bus.d_miss = 1'b1; bus.d_miss_addr = da;
      model_fill(t0, 1'b1, da);
      model_fill(t0 + 14, 1'b0, ia);
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        if (bus.d_fill_done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_d_timeout got no done want done"); end
      @(posedge clk); #1;
      bus.d_miss = 1'b0;
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        if (bus.i_fill_done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_i_timeout got no done want done"); end
      @(posedge clk); #1;
      bus.i_miss = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ev_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL b2b_event_count got %0d want %0d", ev_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < ev_q.size(); k++) begin
        checks++;
        if (ev_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL b2b_event%0d got %h want %h", k, ev_q[k], exp_q[k]);
        end
      end
      checks++;
      if (busy_cnt != exp_busy) begin
        errors++;
        $display("FAIL b2b_busy_cycles got %0d want %0d", busy_cnt, exp_busy);
      end
      $display("b2b: D miss %h then I miss %h, events %0d", da, ia, ev_q.size());
    end
  endtask

  task automatic test_miss_drop();
    int t0;
    bit seen;
    logic [15:0] a;
    a = 16'($urandom);
    @(posedge clk); #1;
    clear_logs();
    t0 = cyc;
    bus.d_miss = 1'b1; bus.d_miss_addr = a;
    model_fill(t0, 1'b1, a);
    repeat (3) @(posedge clk);
    #1;
    bus.d_miss = 1'b0;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bus.d_fill_done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drop_timeout got no done want done"); end
    repeat (4) @(negedge clk);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drop_event_count got %0d want %0d", ev_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < ev_q.size(); k++) begin
      checks++;
      if (ev_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL drop_event%0d got %h want %h", k, ev_q[k], exp_q[k]);
      end
    end
    $display("drop: D miss %h dropped at cycle 3, events %0d", a, ev_q.size());
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] a;
    a = 16'($urandom);
    @(posedge clk); #1;
    clear_logs();
    bus.i_miss = 1'b1; bus.i_miss_addr = a;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_miss = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (6) @(negedge clk);
    checks++;
    if (ev_q.size() != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL stale_valids got events %0d busy %0d want 0 0", ev_q.size(), busy_cnt);
    end
    $display("reset_mid: aborted miss %h, stale events %0d", a, ev_q.size());
    test_single_fill("after_reset", 1'b0, 16'h2000);
  endtask

  initial begin
    salt = 16'($urandom);
    rst = 1'b1;
    bus.i_miss = 1'b0; bus.i_miss_addr = '0;
    bus.d_miss = 1'b0; bus.d_miss_addr = '0;
    test_reset();
    test_i_fill();
    test_back_to_back();
    test_boundary();
    test_miss_drop();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_controller.md
# cache_fill_controller

Miss-service responder between the I-cache/D-cache and the 4-cycle main memory. Accepts a held miss request from either cache, fetches the 16-byte block as eight 16-bit words from main memory, and streams each returned word into the requesting cache's data array. Writes the tag on the last word and pulses a completion strobe. While a cache's miss is outstanding, the CPU pipeline stalls on that cache's miss signal.

## Interface
Parameters:
- ADDR_W, 16, address and data width
- WORDS_PER_BLOCK, 8, words fetched per fill
- OFFSET_BITS, 4, byte-offset bits masked off the miss address

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  I-cache miss request, held high until i_fill_done
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss request, held high until d_fill_done
- d_miss_addr  in  16  D-cache miss byte address
- mem_en  out  1  read request to main memory this cycle
- mem_addr  out  16  word-aligned read address
- mem_data_valid  in  1  main memory returning a word this cycle
- mem_data  in  16  returned word
- fill_data  out  16  word to write into the cache data array (equals mem_data)
- fill_word  out  3  word index within the block for fill_data
- i_data_we / d_data_we  out  1  data-array write enable, I-cache / D-cache
- i_tag_we / d_tag_we  out  1  tag/valid write enable, I-cache / D-cache
- i_fill_done / d_fill_done  out  1  one-cycle completion pulse
- busy  out  1  high in FILL and DONE

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - d_miss=1 → select D. Otherwise i_miss=1 → select I.
  - Latch base = addr & 16'hFFF0. Clear issue_cnt (4 bits) and recv_cnt (3 bits). Go to FILL.
- FILL, issue side:
  - While issue_cnt<8: mem_en=1, mem_addr = base + 2*issue_cnt, then issue_cnt++.
  - When issue_cnt=8: mem_en=0.
- FILL, receive side:
  - On each mem_data_valid, pulse the selected cache's data_we with fill_word=recv_cnt and fill_data=mem_data, then recv_cnt++.
  - Receive counting is independent of issue and may overlap it.
- On the valid with recv_cnt=7: also pulse the selected tag_we in the same cycle, then go to DONE.
- DONE (exactly 1 cycle): pulse the selected fill_done, then go to IDLE. No new request is accepted in DONE.
- Unselected cache: its we/done outputs stay 0 throughout.
- Miss arbitration and ordering:
  - Simultaneous i_miss and d_miss: D is serviced first. I is accepted in the IDLE cycle after DONE, provided i_miss is still held.
  - A miss deasserted mid-fill does not abort the fill; the fill completes and fill_done still pulses.
  - Requests are only sampled in IDLE; a miss arriving during FILL waits.
- Ignored valids: mem_data_valid in IDLE or DONE is ignored (no we pulse, no counter change).
- Address range: base is block-aligned, so base+14 never crosses 16'hFFFF. Block 0xFFF0 issues 0xFFF0…0xFFFE with no wrap.
- Reset: state→IDLE, counters→0, base→0. Valids still in flight from before reset are ignored in IDLE.

## Timing
- Reset values: every output is 0, including mem_addr, fill_data (follows mem_data combinationally, qualified by we), fill_word and busy.
- mem_en and mem_addr are registered-state driven (Moore from issue_cnt/state).
- data_we, tag_we, fill_word and fill_data are combinational from mem_data_valid and recv_cnt.
- fill_done is Moore (DONE state).
- Bench memory model: valid 4 cycles after issue. With the miss seen in IDLE at cycle 0:
  - issues in cycles 1–8
  - data_we in cycles 5–12
  - tag_we in cycle 12
  - fill_done in cycle 13
  - IDLE in cycle 14
- Back-to-back service: the second fill starts accepting at cycle 14 and issues from cycle 15.

## Structure
- Shared package entries:
  - fill_state_t enum {IDLE, FILL, DONE}
  - WORDS_PER_BLOCK
  - OFFSET_BITS
  - the BLOCK_MASK constant 16'hFFF0
- Sub-module fill_word_counter: parameterised-width counter with synchronous clear and enable. It is instantiated twice, for issue_cnt and recv_cnt.

## Test plan
- Reset: rst=1 for 2 cycles with mem_data_valid toggling → all outputs 0, state IDLE, no we pulses.
- I-miss at 0x1236 → mem_addr sequence 0x1230,0x1232,…,0x123E on cycles 1–8. i_data_we fill_word 0–7 on cycles 5–12 carries the model data. i_tag_we at cycle 12, i_fill_done at cycle 13, d_* outputs stay 0.
- Simultaneous i_miss (0x0040) and d_miss (0x8008) → D fill from 0x8000 completes first. I fill from 0x0040 then issues from cycle 15, and only one fill_done fires per fill.
- d_miss at 0xFFFE → addresses 0xFFF0…0xFFFE, no wrap, 8 d_data_we pulses.
- d_miss dropped at cycle 3 → fill still completes with 8 writes, a tag_we and d_fill_done.
- rst asserted at cycle 6 of a fill, then a new i_miss at 0x2000 → the stale valids arriving after reset cause no writes, and the new fill issues exactly 8 fresh addresses.
